// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: drives the select line of a downstream 2:1 mux.
// The select flips on a debounced push-button press and/or periodically
// while automatic mode is enabled. A one-cycle toggle_pulse accompanies
// every change of sel.
module mux_sel_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   input  logic auto_en,
   output logic sel,
   output logic toggle_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(AUTO_PERIOD);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } db_state_t;

   logic          sync1;
   logic          btn_s;
   db_state_t     state;
   db_state_t     state_nxt;
   logic [DW-1:0] db_cnt;
   logic [DW-1:0] db_cnt_nxt;
   logic [PW-1:0] per_cnt;
   logic [PW-1:0] per_cnt_nxt;
   logic          press;
   logic          wrap;
   logic          toggle;

   // Two-flop synchronizer for the asynchronous button input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn_in;
         btn_s <= sync1;
      end
   end

   // Debounce next-state: a level change is accepted only after the new
   // level has been held long enough; only the accepted rising edge is an event
   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      press      = 1'b0;
      case (state)
         STABLE_LO: begin
            if (btn_s) begin
               state_nxt  = WAIT_HI;
               db_cnt_nxt = '0;
            end
         end
         WAIT_HI: begin
            if (!btn_s) begin
               state_nxt = STABLE_LO;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = STABLE_HI;
               press     = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!btn_s) begin
               state_nxt  = WAIT_LO;
               db_cnt_nxt = '0;
            end
         end
         WAIT_LO: begin
            if (btn_s) begin
               state_nxt = STABLE_HI;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = STABLE_LO;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt  = STABLE_LO;
            db_cnt_nxt = '0;
         end
      endcase
   end

   // Period counter next value: idles at zero while automatic mode is off
   always_comb begin
      per_cnt_nxt = '0;
      wrap        = 1'b0;
      if (auto_en) begin
         if (per_cnt == PER_LAST) begin
            wrap = 1'b1;
         end else begin
            per_cnt_nxt = per_cnt + 1'b1;
         end
      end
   end

   // A press and a wrap landing on the same edge merge into one toggle
   assign toggle = press | wrap;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= STABLE_LO;
         db_cnt       <= '0;
         per_cnt      <= '0;
         sel          <= 1'b0;
         toggle_pulse <= 1'b0;
      end else begin
         state        <= state_nxt;
         db_cnt       <= db_cnt_nxt;
         per_cnt      <= per_cnt_nxt;
         sel          <= sel ^ toggle;
         toggle_pulse <= toggle;
      end
   end

endmodule
